// File: rtl/tdc_hit_pkg.sv
// Shared widths, field positions and encoder sentinel codes for the TDC hit buffer.
// Included by the hit buffer, its output interface and the testbench.
package tdc_hit_pkg;

    localparam int TDC_CODE_W = 12;
    localparam int WORD_W     = 24;

    localparam int OVF_BIT    = 23;
    localparam int BCID_MSB   = 22;
    localparam int BCID_LSB   = 12;
    localparam int CODE_MSB   = 11;
    localparam int BCID_FW    = BCID_MSB - BCID_LSB + 1;

    // Encoder emits these when the hit is invalid or the delay line saturated.
    localparam logic [TDC_CODE_W-1:0] INVALID_LO = 12'h000;
    localparam logic [TDC_CODE_W-1:0] INVALID_HI = 12'hFFF;

    typedef struct packed {
        logic                  ovf;
        logic [BCID_FW-1:0]    bcid;
        logic [CODE_MSB:0]     code;
    } hit_word_t;

    function automatic logic code_invalid(input logic [TDC_CODE_W-1:0] code);
        return (code == INVALID_LO) || (code == INVALID_HI);
    endfunction

endpackage

// File: rtl/tdc_hit_buffer_if.sv
// Readout stream from the hit buffer to the serializer (valid/ready).
// The master drives dout/dout_valid; the slave answers with dout_ready.
interface tdc_hit_buffer_if;
    import tdc_hit_pkg::*;

    logic [WORD_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready
    );

endinterface

// File: rtl/tdc_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO with wrap-bit pointers and registered count.
// Latency: a write is visible on rd_data the cycle after its edge; no write-to-read bypass.
// Backpressure: writes are refused when full unless a read pops in the same cycle.
module tdc_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // When full, the slot being written is the one being popped this cycle.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Gate with empty so the output reads zero after reset, not stale storage.
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/tdc_hit_buffer.sv
// Tags TDC hits with a free-running BCID and queues them in an FWFT FIFO; optional TDC_CODE_FILTER_EN discards 0x000/0xFFF codes.
// Latency: a hit appears on dout one cycle after its write edge; no same-cycle bypass.
// Backpressure: dout holds while dout_ready=0; hits arriving on a full FIFO without a pop are dropped and flagged.
module tdc_hit_buffer
    import tdc_hit_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int BCID_W   = 11,
    parameter int BCID_MAX = 1781,
    parameter int DROP_W   = 8
) (
    input  logic                     clk40M,
    input  logic                     rst_n,
    input  logic                     bcid_rst,
    input  logic                     hit_valid,
    input  logic [TDC_CODE_W-1:0]    TDC_bin_code,
    tdc_hit_buffer_if.master         rdout,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic [$clog2(DEPTH):0]   word_cnt,
    output logic [DROP_W-1:0]        drop_cnt
`ifdef TDC_CODE_FILTER_EN
    ,
    output logic [DROP_W-1:0]        filt_cnt
`endif
);

    logic [BCID_W-1:0]  bcid;
    logic               ovf_pending;
    logic               hit_ok;
    logic               rd_fire;
    logic               wr_accept;
    logic               hit_drop;
    hit_word_t          wr_word;
    logic [WORD_W-1:0]  fifo_dout;
    logic               fifo_vld;

    always_ff @(posedge clk40M) begin
        if (!rst_n) begin
            bcid <= '0;
        end else if (bcid_rst) begin
            bcid <= '0;
        end else if (bcid == BCID_W'(BCID_MAX)) begin
            bcid <= '0;
        end else begin
            bcid <= bcid + BCID_W'(1);
        end
    end

`ifdef TDC_CODE_FILTER_EN
    logic code_bad;

    assign code_bad = code_invalid(TDC_bin_code);
    assign hit_ok   = hit_valid && !code_bad;

    always_ff @(posedge clk40M) begin
        if (!rst_n) begin
            filt_cnt <= '0;
        end else if (hit_valid && code_bad && (filt_cnt != '1)) begin
            filt_cnt <= filt_cnt + DROP_W'(1);
        end
    end
`else
    assign hit_ok = hit_valid;
`endif

    assign fifo_vld  = !fifo_empty;
    assign rd_fire   = fifo_vld && rdout.dout_ready;
    assign wr_accept = hit_ok && (!fifo_full || rd_fire);
    assign hit_drop  = hit_ok && fifo_full && !rd_fire;

    always_comb begin
        wr_word      = '0;
        wr_word.ovf  = ovf_pending;
        wr_word.bcid = bcid;
        wr_word.code = TDC_bin_code;
    end

    // ovf_pending marks the first word stored after one or more losses.
    always_ff @(posedge clk40M) begin
        if (!rst_n) begin
            ovf_pending <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            if (hit_drop) begin
                ovf_pending <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + DROP_W'(1);
                end
            end else if (wr_accept) begin
                ovf_pending <= 1'b0;
            end
        end
    end

    tdc_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk40M),
        .rst_n   (rst_n),
        .wr_en   (wr_accept),
        .wr_data (wr_word),
        .rd_en   (rdout.dout_ready),
        .rd_data (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (word_cnt)
    );

    assign rdout.dout       = fifo_dout;
    assign rdout.dout_valid = fifo_vld;

endmodule

// File: tb/tb_tdc_hit_buffer.sv
// Directed bench for tdc_hit_buffer: reset, latency, fill/drop/ovf, full read+write, BCID wrap/clear,
// backpressure stability, drop saturation, mid-run reset and the optional code filter.
module tb_tdc_hit_buffer;
    import tdc_hit_pkg::*;

    logic        clk40M = 1'b0;
    logic        rst_n = 1'b0;
    logic        bcid_rst = 1'b0;
    logic        hit_valid = 1'b0;
    logic [11:0] TDC_bin_code = '0;
    logic        fifo_full;
    logic        fifo_empty;
    logic [4:0]  word_cnt;
    logic [7:0]  drop_cnt;
`ifdef TDC_CODE_FILTER_EN
    logic [7:0]  filt_cnt;
`endif

    tdc_hit_buffer_if bus();

    int          checks = 0;
    int          errors = 0;
    int          m_bcid = 0;
    logic [23:0] exp_q[$];
    logic [11:0] fcodes [3];

    always #12 clk40M = ~clk40M;

    tdc_hit_buffer #(
        .DEPTH    (16),
        .BCID_W   (11),
        .BCID_MAX (1781),
        .DROP_W   (8)
    ) dut (
        .clk40M       (clk40M),
        .rst_n        (rst_n),
        .bcid_rst     (bcid_rst),
        .hit_valid    (hit_valid),
        .TDC_bin_code (TDC_bin_code),
        .rdout        (bus),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .word_cnt     (word_cnt),
        .drop_cnt     (drop_cnt)
`ifdef TDC_CODE_FILTER_EN
        ,
        .filt_cnt     (filt_cnt)
`endif
    );

    // Reference BCID: value held by the counter during the current cycle.
    always @(posedge clk40M) begin
        if (!rst_n || bcid_rst)  m_bcid <= 0;
        else if (m_bcid == 1781) m_bcid <= 0;
        else                     m_bcid <= m_bcid + 1;
    end

    task automatic tick();
        @(posedge clk40M);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [11:0] code, input logic ovf);
        hit_valid    = 1'b1;
        TDC_bin_code = code;
        exp_q.push_back({ovf, 11'(m_bcid), code});
        tick();
        hit_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        logic [23:0] e;
        bus.dout_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hBADBAD;
            check("drain_vld", bus.dout_valid, 1);
            check("drain_dat", bus.dout, e);
            tick();
        end
        bus.dout_ready = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] e;
        int          popped;
        logic        rdy;

        bus.dout_ready = 1'b0;
        fcodes[0] = 12'h000;
        fcodes[1] = 12'hFFF;
        fcodes[2] = 12'h001;

        // Reset state
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_dout", bus.dout, 0);
        check("rst_vld", bus.dout_valid, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_wcnt", word_cnt, 0);
        check("rst_drop", drop_cnt, 0);

        // Single hit at bcid=5, one-cycle latency, no bypass
        repeat (5) tick();
        hit_valid    = 1'b1;
        TDC_bin_code = 12'h2A5;
        #1;
        check("no_bypass", bus.dout_valid, 0);
        tick();
        hit_valid = 1'b0;
        check("hit1_vld", bus.dout_valid, 1);
        check("hit1_dat", bus.dout, 24'h0052A5);
        check("hit1_wcnt", word_cnt, 1);
        bus.dout_ready = 1'b1;
        tick();
        check("pop_empty", fifo_empty, 1);
        check("pop_vld", bus.dout_valid, 0);
        tick();
        check("rd_on_empty", word_cnt, 0);
        bus.dout_ready = 1'b0;

        // Fill, then three drops
        for (int i = 0; i < 16; i++) send(12'(12'h100 + i), 1'b0);
        check("fill_full", fifo_full, 1);
        check("fill_wcnt", word_cnt, 16);
        for (int i = 0; i < 3; i++) begin
            hit_valid    = 1'b1;
            TDC_bin_code = 12'(12'h200 + i);
            tick();
        end
        hit_valid = 1'b0;
        check("drop3", drop_cnt, 3);
        check("drop_wcnt", word_cnt, 16);
        check("drop_head", bus.dout, exp_q[0]);
        drain(1);
        check("drain1_wcnt", word_cnt, 15);
        send(12'h300, 1'b1);
        check("refill_full", fifo_full, 1);
        drain(16);
        send(12'h301, 1'b0);
        drain(1);
        check("ovf_empty", fifo_empty, 1);

        // Full with simultaneous read and write
        for (int i = 0; i < 16; i++) send(12'(12'h400 + i), 1'b0);
        e = exp_q.pop_front();
        check("rw_head", bus.dout, e);
        exp_q.push_back({1'b0, 11'(m_bcid), 12'h500});
        bus.dout_ready = 1'b1;
        hit_valid      = 1'b1;
        TDC_bin_code   = 12'h500;
        tick();
        bus.dout_ready = 1'b0;
        hit_valid      = 1'b0;
        check("rw_wcnt", word_cnt, 16);
        check("rw_full", fifo_full, 1);
        check("rw_drop", drop_cnt, 3);
        drain(16);
        check("rw_empty", fifo_empty, 1);

        // BCID wrap 1781 -> 0
        bcid_rst = 1'b1;
        tick();
        bcid_rst = 1'b0;
        repeat (1781) tick();
        hit_valid    = 1'b1;
        TDC_bin_code = 12'h0AA;
        tick();
        TDC_bin_code = 12'h0AB;
        tick();
        hit_valid = 1'b0;
        exp_q.push_back(24'h6F50AA);
        exp_q.push_back(24'h0000AB);
        drain(2);

        // bcid_rst asserted in the cycle where bcid=100
        bcid_rst = 1'b1;
        tick();
        bcid_rst = 1'b0;
        repeat (100) tick();
        bcid_rst     = 1'b1;
        hit_valid    = 1'b1;
        TDC_bin_code = 12'h0CC;
        tick();
        bcid_rst     = 1'b0;
        TDC_bin_code = 12'h0CD;
        tick();
        TDC_bin_code = 12'h0CE;
        tick();
        hit_valid = 1'b0;
        exp_q.push_back(24'h0640CC);
        exp_q.push_back(24'h0000CD);
        exp_q.push_back(24'h0010CE);
        drain(3);

        // Backpressure: ready toggles, output holds while stalled
        for (int i = 0; i < 4; i++) send(12'(12'h0D0 + i), 1'b0);
        popped = 0;
        rdy    = 1'b0;
        for (int c = 0; c < 20 && popped < 4; c++) begin
            bus.dout_ready = rdy;
            if (rdy) begin
                e = exp_q.pop_front();
                check("bp_dat", bus.dout, e);
                tick();
                popped++;
            end else begin
                tick();
                check("bp_hold_vld", bus.dout_valid, 1);
                check("bp_hold_dat", bus.dout, exp_q[0]);
            end
            rdy = !rdy;
        end
        bus.dout_ready = 1'b0;
        check("bp_count", popped, 4);
        check("bp_nodup", bus.dout_valid, 0);

        // Drop counter saturation
        for (int i = 0; i < 16; i++) send(12'(12'h600 + i), 1'b0);
        hit_valid    = 1'b1;
        TDC_bin_code = 12'h6FF;
        repeat (300) tick();
        hit_valid = 1'b0;
        check("drop_sat", drop_cnt, 255);
        check("sat_wcnt", word_cnt, 16);

        // Reset mid-operation discards contents
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        check("mrst_vld", bus.dout_valid, 0);
        check("mrst_dout", bus.dout, 0);
        check("mrst_wcnt", word_cnt, 0);
        check("mrst_drop", drop_cnt, 0);
        check("mrst_full", fifo_full, 0);

        // Sentinel codes: filtered only when the filter is built in
        for (int k = 0; k < 3; k++) begin
`ifdef TDC_CODE_FILTER_EN
            if (k == 2) exp_q.push_back({1'b0, 11'(m_bcid), fcodes[k]});
`else
            exp_q.push_back({1'b0, 11'(m_bcid), fcodes[k]});
`endif
            hit_valid    = 1'b1;
            TDC_bin_code = fcodes[k];
            tick();
        end
        hit_valid = 1'b0;
`ifdef TDC_CODE_FILTER_EN
        check("filt_wcnt", word_cnt, 1);
        check("filt_cnt", filt_cnt, 2);
`else
        check("nofilt_wcnt", word_cnt, 3);
`endif
        check("filt_drop", drop_cnt, 0);
        drain(exp_q.size());
        check("filt_empty", fifo_empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdc_hit_buffer.md
Name: tdc_hit_buffer

Overview:
- Downstream consumer of the TDC encoder's 12-bit binary code.
- Tags each valid hit with a free-running bunch-crossing ID (BCID) and stores the tagged word in a synchronous first-word-fall-through (FWFT) FIFO.
- Presents stored words to the readout serializer over a valid/ready handshake and flags lost hits.

Parameters:
- DEPTH, 16, FIFO depth in words; power of 2, minimum 4.
- BCID_W, 11, BCID counter width.
- BCID_MAX, 1781, terminal BCID value; the counter wraps to 0 after this value.
- DROP_W, 8, width of the drop counter.

Ports:
- clk40M  input  1  40 MHz system clock.
- rst_n  input  1  synchronous active-low reset.
- bcid_rst  input  1  synchronous clear of the BCID counter.
- hit_valid  input  1  TDC_bin_code is valid this cycle.
- TDC_bin_code  input  12  encoded TDC code from the TDC encoder.
- dout  output  24  data word {ovf, bcid[10:0], code[11:0]}.
- dout_valid  output  1  dout holds a word.
- dout_ready  input  1  consumer accepts the word.
- fifo_full  output  1  FIFO occupancy equals DEPTH.
- fifo_empty  output  1  FIFO occupancy equals 0.
- word_cnt  output  $clog2(DEPTH)+1  current FIFO occupancy.
- drop_cnt  output  DROP_W  number of hits lost while the FIFO was full; saturates.

Behaviour:
- Reset: one clk40M edge with rst_n=0 clears everything.
  - After reset: dout=0, dout_valid=0, fifo_empty=1, fifo_full=0, word_cnt=0, drop_cnt=0, bcid=0, ovf_pending=0.
  - Reset mid-operation discards all stored words.
- BCID counter:
  - Increments every cycle.
  - BCID_MAX -> 0.
  - bcid_rst=1 forces the counter to 0 on the next edge; bcid_rst overrides increment.
- Write:
  - Occurs when hit_valid=1 and the FIFO can accept.
  - Stored word = {ovf_pending, bcid (value in the hit cycle), TDC_bin_code}.
  - ovf_pending clears when a word is stored.
- Accept condition: !fifo_full, or fifo_full with a read in the same cycle (dout_valid & dout_ready).
  - A simultaneous read and write when full: both happen; word_cnt stays at DEPTH.
- Drop:
  - Occurs when hit_valid=1 and the FIFO is full with no read in that cycle.
  - drop_cnt increments, saturating at 2^DROP_W-1.
  - ovf_pending sets to 1.
- Read:
  - Occurs when dout_valid & dout_ready.
  - The FIFO pops; the next word, if any, appears on dout after the edge.
  - dout_ready while empty has no effect.
- Latency and ordering:
  - A hit written into an empty FIFO gives dout_valid=1 on the cycle after the write edge (1-cycle latency).
  - There is no same-cycle bypass.
- Output stability: dout and dout_valid stay stable while dout_valid=1 and dout_ready=0.
- Simultaneous read and write when empty: only the write takes effect, since there is nothing to read.
- Pointers:
  - Read and write pointers are $clog2(DEPTH)+1 bits with a wrap bit.
  - full = MSBs differ & LSBs equal.
  - empty = pointers equal.
- word_cnt updates on the same edge as the write/read; it is registered.

Optional Feature:
- Macro: TDC_CODE_FILTER_EN.
- Defined:
  - A hit whose TDC_bin_code equals 12'h000 or 12'hFFF (encoder invalid/saturation) is discarded.
  - A discarded hit is never written, does not count as a drop, and does not touch ovf_pending.
  - An extra output port filt_cnt[DROP_W-1:0] counts discarded hits, saturates, and resets to 0.
- Undefined: every valid hit is written; filt_cnt does not exist.

Decomposition:
- Package tdc_hit_pkg holds:
  - TDC_CODE_W=12 and WORD_W=24;
  - field positions OVF_BIT=23, BCID_MSB=22, BCID_LSB=12, CODE_MSB=11;
  - codes INVALID_LO=12'h000 and INVALID_HI=12'hFFF.
- Sub-module tdc_sync_fifo is a generic FWFT synchronous FIFO, parameterised by WIDTH/DEPTH, providing full/empty/count.
- tdc_hit_buffer holds the BCID counter, drop/ovf logic, the optional filter, and the FIFO instance.

Test Plan:
- Reset then single hit: hit_valid=1, code=12'h2A5 at bcid=5 -> next cycle dout_valid=1, dout={1'b0,11'd5,12'h2A5}; dout_ready=1 -> fifo_empty=1.
- Fill and drop: dout_ready=0, 16 hits, then 3 more -> fifo_full=1, word_cnt=16, drop_cnt=3. Drain one word, write one hit -> that word has ovf=1; the next hit has ovf=0.
- Full with simultaneous read and write: full FIFO, dout_ready=1 and hit_valid=1 -> word_cnt stays 16, drop_cnt unchanged, order preserved.
- BCID wrap and clear: run 1782 cycles -> bcid goes 1781 -> 0. Assert bcid_rst at bcid=100 -> the next hit is tagged bcid=0 or 1 per its cycle offset.
- Backpressure: 4 hits, dout_ready toggling 0/1 each cycle -> dout stable while stalled; the 4 words come out in order with no duplicates.
- Filter (with TDC_CODE_FILTER_EN): hits 12'h000, 12'hFFF, 12'h001 -> only 12'h001 is stored, filt_cnt=2, drop_cnt=0. Without the macro: all 3 are stored.
